// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - request/response and 68030-style bus signals of bus_master
interface bus_master_if;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic [31:0] reqWdata;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic [31:0] busAddr;
    logic [31:0] busDataOut;
    logic        busDataOe;
    logic [31:0] busDataIn;
    logic        busASn;
    logic        busDSn;
    logic        busRWn;
    logic [1:0]  busSIZ;
    logic [1:0]  busDSACKn;
    logic        busBERRn;

    modport master (
        input  reqValid, reqAddr, reqWrite, reqSize, reqWdata,
        input  busDataIn, busDSACKn, busBERRn,
        output reqReady, rspValid, rspRdata, rspErr,
        output busAddr, busDataOut, busDataOe, busASn, busDSn, busRWn, busSIZ
    );

    modport slave (
        output reqValid, reqAddr, reqWrite, reqSize, reqWdata,
        output busDataIn, busDSACKn, busBERRn,
        input  reqReady, rspValid, rspRdata, rspErr,
        input  busAddr, busDataOut, busDataOe, busASn, busDSn, busRWn, busSIZ
    );
endinterface

// File: rtl/bus_master.sv
// rtl/bus_master.sv - initiator for a 68030-style asynchronous bus with dynamic port sizing
module bus_master (
    input  logic         sysClk,
    input  logic         sysRESET,
    bus_master_if.master busPort
);
    typedef enum logic [2:0] {IDLE, ADR, ASRT, WDS, WAIT, TERM, RECOV, RESP} state_e;

    state_e      state;
    logic        reqReadyR, rspValidR, rspErrR;
    logic [31:0] rspRdataR, addrR, dataOutR, operand, wShift;
    logic        dataOeR, asnR, dsnR, rwnR, isWrite, errFlag;
    logic [1:0]  sizR;
    logic [2:0]  remaining, xferBytes;
    logic [7:0]  timer;

    logic        ackSeen;
    logic [2:0]  portBytes, offset, avail, nBytes, remInit;
    logic [31:0] laneData, nextOperand, firstOut, wShiftInit;

    assign ackSeen = (busPort.busDSACKn != 2'b11);

    // Port geometry for the cycle being terminated; the first lane of valid data equals the offset.
    always_comb begin
        portBytes = 3'd4;
        offset    = {1'b0, addrR[1:0]};
        case (busPort.busDSACKn)
            2'b10:   begin portBytes = 3'd1; offset = 3'd0;               end
            2'b01:   begin portBytes = 3'd2; offset = {2'b00, addrR[0]};  end
            default: begin portBytes = 3'd4; offset = {1'b0, addrR[1:0]}; end
        endcase
        avail       = portBytes - offset;
        nBytes      = (remaining < avail) ? remaining : avail;
        laneData    = busPort.busDataIn << {offset[1:0], 3'b000};
        nextOperand = (operand << {nBytes, 3'b000}) | (laneData >> (6'd32 - {nBytes, 3'b000}));
    end

    always_comb begin
        case (busPort.reqSize)
            2'b01: begin
                remInit    = 3'd1;
                firstOut   = {4{busPort.reqWdata[7:0]}};
                wShiftInit = {busPort.reqWdata[7:0], 24'h0};
            end
            2'b10: begin
                remInit    = 3'd2;
                firstOut   = {2{busPort.reqWdata[15:0]}};
                wShiftInit = {busPort.reqWdata[15:0], 16'h0};
            end
            default: begin
                remInit    = 3'd4;
                firstOut   = busPort.reqWdata;
                wShiftInit = busPort.reqWdata;
            end
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (sysRESET) begin
            state     <= IDLE;
            reqReadyR <= 1'b1;
            rspValidR <= 1'b0;
            rspErrR   <= 1'b0;
            rspRdataR <= 32'h0;
            addrR     <= 32'h0;
            dataOutR  <= 32'h0;
            dataOeR   <= 1'b0;
            asnR      <= 1'b1;
            dsnR      <= 1'b1;
            rwnR      <= 1'b1;
            sizR      <= 2'b00;
            isWrite   <= 1'b0;
            errFlag   <= 1'b0;
            remaining <= 3'd0;
            xferBytes <= 3'd0;
            timer     <= 8'hFF;
            operand   <= 32'h0;
            wShift    <= 32'h0;
        end else begin
            rspValidR <= 1'b0;
            case (state)
                IDLE: if (busPort.reqValid && reqReadyR) begin
                    reqReadyR <= 1'b0;
                    addrR     <= busPort.reqAddr;
                    isWrite   <= busPort.reqWrite;
                    rwnR      <= ~busPort.reqWrite;
                    remaining <= remInit;
                    sizR      <= remInit[1:0];
                    dataOutR  <= firstOut;
                    wShift    <= wShiftInit;
                    dataOeR   <= busPort.reqWrite;
                    timer     <= 8'hFF;
                    errFlag   <= 1'b0;
                    operand   <= 32'h0;
                    state     <= ADR;
                end
                ADR: begin
                    asnR  <= 1'b0;
                    dsnR  <= isWrite;
                    state <= ASRT;
                end
                ASRT: begin
                    if (isWrite) begin
                        dsnR  <= 1'b0;
                        state <= WDS;
                    end else begin
                        state <= WAIT;
                    end
                end
                WDS: state <= WAIT;
                WAIT: begin
                    if (!busPort.busBERRn || ackSeen || timer == 8'h00) begin
                        if (!busPort.busBERRn || !ackSeen) begin
                            errFlag   <= 1'b1;
                            xferBytes <= 3'd0;
                        end else begin
                            xferBytes <= nBytes;
                            if (!isWrite) operand <= nextOperand;
                        end
                        asnR    <= 1'b1;
                        dsnR    <= 1'b1;
                        dataOeR <= 1'b0;
                        state   <= TERM;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                TERM: begin
                    addrR     <= addrR + {29'h0, xferBytes};
                    remaining <= remaining - xferBytes;
                    wShift    <= wShift << {xferBytes, 3'b000};
                    timer     <= 8'hFF;
                    state     <= RECOV;
                end
                RECOV: begin
                    if (!ackSeen && busPort.busBERRn) begin
                        if (remaining != 3'd0 && !errFlag) begin
                            sizR     <= remaining[1:0];
                            dataOutR <= wShift;
                            dataOeR  <= isWrite;
                            timer    <= 8'hFF;
                            state    <= ADR;
                        end else begin
                            rspValidR <= 1'b1;
                            rspRdataR <= operand;
                            rspErrR   <= errFlag;
                            state     <= RESP;
                        end
                    end else if (timer == 8'h00) begin
                        // Terminator stuck asserted: give up and report an error.
                        errFlag   <= 1'b1;
                        rspValidR <= 1'b1;
                        rspRdataR <= operand;
                        rspErrR   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                RESP: begin
                    reqReadyR <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busPort.reqReady   = reqReadyR;
    assign busPort.rspValid   = rspValidR;
    assign busPort.rspRdata   = rspRdataR;
    assign busPort.rspErr     = rspErrR;
    assign busPort.busAddr    = addrR;
    assign busPort.busDataOut = dataOutR;
    assign busPort.busDataOe  = dataOeR;
    assign busPort.busASn     = asnR;
    assign busPort.busDSn     = dsnR;
    assign busPort.busRWn     = rwnR;
    assign busPort.busSIZ     = sizR;
endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - directed bench for bus_master with a reactive bus responder
module tb_bus_master;
    logic sysClk = 1'b0;
    logic sysRESET;

    bus_master_if busIf();

    bus_master dut (
        .sysClk   (sysClk),
        .sysRESET (sysRESET),
        .busPort  (busIf)
    );

    always #5 sysClk = ~sysClk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rdIn    [4];
    logic [31:0] addrLog [8];
    logic [31:0] doutLog [8];
    logic [1:0]  sizLog  [8];
    logic        rwnLog  [8];
    logic        oeLog   [32];
    int          nCyc, latency, asLow, dsLow;
    logic [31:0] gotRdata;
    logic        gotErr, strobesAtRsp;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request and plays the slave; latency counts cycles after the accepting edge.
    task automatic runTxn(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [1:0] port, input int berrIdx,
                          input bit noAck, input int resetAt);
        int k;
        bit acked, done, sawRsp;
        nCyc = 0; latency = -1; asLow = -1; dsLow = -1;
        gotRdata = 32'h0; gotErr = 1'b0; strobesAtRsp = 1'b0;
        acked = 0; done = 0;
        for (int i = 0; i < 32; i++) oeLog[i] = 1'b0;
        @(negedge sysClk);
        busIf.reqValid = 1'b1;
        busIf.reqAddr  = addr;
        busIf.reqWrite = wr;
        busIf.reqSize  = size;
        busIf.reqWdata = wdata;
        k = 0;
        while (!busIf.reqReady && k < 10) begin
            @(negedge sysClk);
            k++;
        end
        @(negedge sysClk);
        busIf.reqValid = 1'b0;
        k = 1;
        while (!done && k < 400) begin
            oeLog[k % 32] = (k < 32) ? busIf.busDataOe : oeLog[k % 32];
            if (!busIf.busASn && asLow < 0) asLow = k;
            if (!busIf.busDSn && dsLow < 0) dsLow = k;
            if (busIf.rspValid) begin
                latency      = k;
                gotRdata     = busIf.rspRdata;
                gotErr       = busIf.rspErr;
                strobesAtRsp = busIf.busASn & busIf.busDSn;
                done         = 1;
            end else if (k == resetAt) begin
                sysRESET = 1'b1;
                @(negedge sysClk);
                checkEq("rstAsn", busIf.busASn, 1);
                checkEq("rstDsn", busIf.busDSn, 1);
                checkEq("rstRspValid", busIf.rspValid, 0);
                checkEq("rstReqReady", busIf.reqReady, 1);
                sysRESET = 1'b0;
                busIf.busDSACKn = 2'b11;
                busIf.busBERRn  = 1'b1;
                sawRsp = 0;
                for (int j = 0; j < 8; j++) begin
                    @(negedge sysClk);
                    if (busIf.rspValid) sawRsp = 1;
                end
                checkEq("rstNoRsp", sawRsp, 0);
                latency = -2;
                done    = 1;
            end else if (!busIf.busASn && !busIf.busDSn && !acked) begin
                if (nCyc < 8) begin
                    addrLog[nCyc] = busIf.busAddr;
                    sizLog[nCyc]  = busIf.busSIZ;
                    doutLog[nCyc] = busIf.busDataOut;
                    rwnLog[nCyc]  = busIf.busRWn;
                end
                if (nCyc == berrIdx) begin
                    busIf.busBERRn = 1'b0;
                end else if (!noAck) begin
                    busIf.busDSACKn = port;
                    busIf.busDataIn = rdIn[nCyc % 4];
                end
                acked = 1;
                nCyc++;
            end else if (busIf.busASn && acked) begin
                busIf.busDSACKn = 2'b11;
                busIf.busBERRn  = 1'b1;
                busIf.busDataIn = 32'h0;
                acked = 0;
            end
            if (!done) begin
                @(negedge sysClk);
                k++;
            end
        end
        busIf.busDSACKn = 2'b11;
        busIf.busBERRn  = 1'b1;
        busIf.busDataIn = 32'h0;
    endtask

    initial begin
        busIf.reqValid  = 1'b0;
        busIf.reqAddr   = 32'h0;
        busIf.reqWrite  = 1'b0;
        busIf.reqSize   = 2'b00;
        busIf.reqWdata  = 32'h0;
        busIf.busDataIn = 32'h0;
        busIf.busDSACKn = 2'b11;
        busIf.busBERRn  = 1'b1;
        sysRESET = 1'b1;
        repeat (3) @(negedge sysClk);
        sysRESET = 1'b0;

        checkEq("resetReqReady", busIf.reqReady, 1);
        checkEq("resetAsnDsn", {busIf.busASn, busIf.busDSn, busIf.busRWn}, 3'b111);
        checkEq("resetOeRsp", {busIf.busDataOe, busIf.rspValid, busIf.rspErr}, 3'b000);
        checkEq("resetAddr", busIf.busAddr, 32'h0);
        checkEq("resetDout", busIf.busDataOut, 32'h0);
        checkEq("resetSiz", busIf.busSIZ, 2'b00);
        checkEq("resetRdata", busIf.rspRdata, 32'h0);

        // Long read, 32-bit port
        rdIn[0] = 32'h11223344;
        runTxn(32'h00001000, 1'b0, 2'b00, 32'h0, 2'b00, -1, 0, -1);
        checkEq("lr32Cycles", nCyc, 1);
        checkEq("lr32Siz", sizLog[0], 2'b00);
        checkEq("lr32Addr", addrLog[0], 32'h00001000);
        checkEq("lr32Rwn", rwnLog[0], 1);
        checkEq("lr32Rdata", gotRdata, 32'h11223344);
        checkEq("lr32Err", gotErr, 0);
        checkEq("lr32Latency", latency, 6);

        // Long read, 8-bit port: junk on lanes 1..3 must be ignored
        rdIn[0] = 32'hAA5A5A5A; rdIn[1] = 32'hBB123456; rdIn[2] = 32'hCC00FF00; rdIn[3] = 32'hDDFFFFFF;
        runTxn(32'h00F00000, 1'b0, 2'b00, 32'h0, 2'b10, -1, 0, -1);
        checkEq("lr8Cycles", nCyc, 4);
        checkEq("lr8Sizes", {sizLog[0], sizLog[1], sizLog[2], sizLog[3]}, 8'b00_11_10_01);
        checkEq("lr8Addr1", addrLog[1], 32'h00F00001);
        checkEq("lr8Addr3", addrLog[3], 32'h00F00003);
        checkEq("lr8Rdata", gotRdata, 32'hAABBCCDD);
        checkEq("lr8Latency", latency, 21);

        // Word write, 16-bit port
        runTxn(32'h00000002, 1'b1, 2'b10, 32'h5A5A1234, 2'b01, -1, 0, -1);
        checkEq("ww16Cycles", nCyc, 1);
        checkEq("ww16Dout", doutLog[0], 32'h12341234);
        checkEq("ww16Siz", sizLog[0], 2'b10);
        checkEq("ww16Rwn", rwnLog[0], 0);
        checkEq("ww16AsCycle", asLow, 2);
        checkEq("ww16DsCycle", dsLow, 3);
        checkEq("ww16OeAdrWait", {oeLog[1], oeLog[2], oeLog[3], oeLog[4]}, 4'b1111);
        checkEq("ww16OeTerm", oeLog[5], 0);
        checkEq("ww16Latency", latency, 7);
        checkEq("ww16Err", gotErr, 0);

        // Long write, 8-bit port: remaining bytes left-justified each cycle
        runTxn(32'h00000020, 1'b1, 2'b00, 32'h01020304, 2'b10, -1, 0, -1);
        checkEq("lw8Cycles", nCyc, 4);
        checkEq("lw8Dout0", doutLog[0], 32'h01020304);
        checkEq("lw8Dout1", doutLog[1], 32'h02030400);
        checkEq("lw8Dout3", doutLog[3], 32'h04000000);
        checkEq("lw8Latency", latency, 25);

        // Byte write replicated on all lanes
        runTxn(32'h00000001, 1'b1, 2'b01, 32'hFFFFFF77, 2'b00, -1, 0, -1);
        checkEq("bwDout", doutLog[0], 32'h77777777);
        checkEq("bwSiz", sizLog[0], 2'b01);
        checkEq("bwLatency", latency, 7);

        // Byte read from lane 2 of a 32-bit port
        rdIn[0] = 32'h11223344;
        runTxn(32'h00000002, 1'b0, 2'b01, 32'h0, 2'b00, -1, 0, -1);
        checkEq("br32Rdata", gotRdata, 32'h00000033);
        checkEq("br32Latency", latency, 6);

        // No acknowledge: timeout after 256 WAIT cycles
        runTxn(32'h00000003, 1'b0, 2'b01, 32'h0, 2'b00, -1, 1, -1);
        checkEq("toErr", gotErr, 1);
        checkEq("toLatency", latency, 261);
        checkEq("toStrobes", strobesAtRsp, 1);
        checkEq("toCycles", nCyc, 1);

        // Bus error on second cycle of a 16-bit long read
        rdIn[0] = 32'hCAFE0000; rdIn[1] = 32'hBEEF0000;
        runTxn(32'h00000100, 1'b0, 2'b00, 32'h0, 2'b01, 1, 0, -1);
        checkEq("beCycles", nCyc, 2);
        checkEq("beSiz1", sizLog[1], 2'b10);
        checkEq("beAddr1", addrLog[1], 32'h00000102);
        checkEq("beErr", gotErr, 1);
        checkEq("beLatency", latency, 11);

        // Reset pulsed during WAIT, then a normal request
        runTxn(32'h00000000, 1'b0, 2'b00, 32'h0, 2'b00, -1, 1, 4);
        rdIn[0] = 32'hDEADBEEF;
        runTxn(32'h00000000, 1'b0, 2'b00, 32'h0, 2'b00, -1, 0, -1);
        checkEq("postRstRdata", gotRdata, 32'hDEADBEEF);
        checkEq("postRstErr", gotErr, 0);
        checkEq("postRstLatency", latency, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
